// File: rtl/text_tile_addr_gen_pkg.sv
// Shared text-grid defaults, derived widths and FSM encoding for the text tile path.
package vga_text_pkg;

  localparam int unsigned CHAR_W     = 8;
  localparam int unsigned CHAR_H     = 16;
  localparam int unsigned COLS       = 80;
  localparam int unsigned ROWS       = 30;
  localparam int unsigned CODE_W     = 7;
  localparam int unsigned BLANK_CODE = 0;

  localparam int unsigned CHAR_X_W = $clog2(CHAR_W);
  localparam int unsigned CHAR_Y_W = $clog2(CHAR_H);
  localparam int unsigned COL_W    = $clog2(COLS);
  localparam int unsigned ROW_W    = $clog2(ROWS);
  localparam int unsigned CELLS    = COLS * ROWS;
  localparam int unsigned CELL_W   = $clog2(CELLS);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/text_tile_addr_gen_char_buffer.sv
// Character buffer: one write port, one registered read port, read-before-write.
module text_char_buffer #(
  parameter int unsigned DEPTH  = 2400,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 7
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Both ports update on the same edge with non-blocking writes, so a same-address
  // read returns the contents from before this edge's write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/text_tile_addr_gen.sv
// Text-mode tile address generator: pixel position -> {code, glyph_row} + bit select.
module text_tile_addr_gen
  import vga_text_pkg::*;
#(
  parameter int unsigned X_W          = 10,
  parameter int unsigned Y_W          = 10,
  parameter int unsigned CHAR_W       = vga_text_pkg::CHAR_W,
  parameter int unsigned CHAR_H       = vga_text_pkg::CHAR_H,
  parameter int unsigned COLS         = vga_text_pkg::COLS,
  parameter int unsigned ROWS         = vga_text_pkg::ROWS,
  parameter int unsigned CODE_W       = vga_text_pkg::CODE_W,
  parameter int unsigned BLANK_CODE   = vga_text_pkg::BLANK_CODE,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                pixel_tick,
  input  logic [X_W-1:0]                      pixel_x,
  input  logic [Y_W-1:0]                      pixel_y,
  input  logic                                video_on,
  input  logic                                frame_start,
  input  logic                                wr_en,
  input  logic [$clog2(COLS)-1:0]             wr_col,
  input  logic [$clog2(ROWS)-1:0]             wr_row,
  input  logic [CODE_W-1:0]                   wr_code,
  output logic                                wr_ready,
  input  logic                                cursor_en,
  input  logic [$clog2(COLS)-1:0]             cursor_col,
  input  logic [$clog2(ROWS)-1:0]             cursor_row,
  output logic [CODE_W+$clog2(CHAR_H)-1:0]    rom_addr,
  output logic [$clog2(CHAR_W)-1:0]           bit_sel,
  output logic                                cursor_hit,
  output logic                                pix_valid
);

  localparam int unsigned CX_W    = $clog2(CHAR_W);
  localparam int unsigned CY_W    = $clog2(CHAR_H);
  localparam int unsigned NCELLS  = COLS * ROWS;
  localparam int unsigned ADDR_W  = $clog2(NCELLS);
  localparam int unsigned PCOL_W  = X_W - CX_W;
  localparam int unsigned PROW_W  = Y_W - CY_W;
  localparam int unsigned BLINK_W = $clog2(BLINK_FRAMES + 1);
  localparam int unsigned ROM_W   = CODE_W + CY_W;

  localparam logic [CODE_W-1:0] BLANK = CODE_W'(BLANK_CODE);

  // Clear FSM / buffer write port
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
  logic                wr_ready_q, wr_ready_d;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [CODE_W-1:0]   mem_wdata;
  logic [ADDR_W-1:0]   wr_addr;
  logic                wr_in_range;

  assign wr_in_range = (32'(wr_col) < COLS) && (32'(wr_row) < ROWS);
  assign wr_addr     = ADDR_W'(32'(wr_row) * COLS + 32'(wr_col));

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    wr_ready_d = wr_ready_q;
    mem_we     = 1'b0;
    mem_waddr  = wr_addr;
    mem_wdata  = wr_code;
    case (state_q)
      CLEAR: begin
        mem_we     = 1'b1;
        mem_waddr  = clr_addr_q;
        mem_wdata  = BLANK;
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (32'(clr_addr_q) == NCELLS - 1) begin
          state_d    = RUN;
          wr_ready_d = 1'b1;
          clr_addr_d = '0;
        end
      end
      RUN: begin
        mem_we = wr_en && wr_in_range;
      end
      default: begin
        state_d    = CLEAR;
        clr_addr_d = '0;
        wr_ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      wr_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  assign wr_ready = wr_ready_q;

  // Stage 1: cell lookup
  logic [PCOL_W-1:0] px_col;
  logic [PROW_W-1:0] px_row;
  logic              in_area;
  logic              cur_match;
  logic [ADDR_W-1:0] rd_addr;
  logic [CODE_W-1:0] rd_data;

  assign px_col    = pixel_x[X_W-1:CX_W];
  assign px_row    = pixel_y[Y_W-1:CY_W];
  assign in_area   = video_on && (32'(px_col) < COLS) && (32'(px_row) < ROWS);
  assign rd_addr   = in_area ? ADDR_W'(32'(px_row) * COLS + 32'(px_col)) : '0;
  assign cur_match = cursor_en && (32'(px_col) == 32'(cursor_col))
                     && (32'(px_row) == 32'(cursor_row));

  text_char_buffer #(
    .DEPTH  (NCELLS),
    .ADDR_W (ADDR_W),
    .DATA_W (CODE_W)
  ) u_buf (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (pixel_tick),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  logic [CY_W-1:0]   glyph_row_q, glyph_row_d;
  logic [CX_W-1:0]   bit_sel_s1_q, bit_sel_s1_d;
  logic              in_area_s1_q, in_area_s1_d;
  logic              rd_ok_s1_q, rd_ok_s1_d;
  logic              match_s1_q, match_s1_d;
  logic              video_on_s1_q, video_on_s1_d;

  // Stage 2: outputs
  logic [ROM_W-1:0]  rom_addr_q, rom_addr_d;
  logic [CX_W-1:0]   bit_sel_q, bit_sel_d;
  logic              cursor_hit_q, cursor_hit_d;
  logic              pix_valid_q, pix_valid_d;
  logic [CODE_W-1:0] code;

  // Blink
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;

  // Buffer data is only trusted when the read was issued after the clear finished.
  assign code = rd_ok_s1_q ? rd_data : BLANK;

  always_comb begin
    glyph_row_d   = glyph_row_q;
    bit_sel_s1_d  = bit_sel_s1_q;
    in_area_s1_d  = in_area_s1_q;
    rd_ok_s1_d    = rd_ok_s1_q;
    match_s1_d    = match_s1_q;
    video_on_s1_d = video_on_s1_q;
    rom_addr_d    = rom_addr_q;
    bit_sel_d     = bit_sel_q;
    cursor_hit_d  = cursor_hit_q;
    pix_valid_d   = pix_valid_q;
    if (pixel_tick) begin
      glyph_row_d   = pixel_y[CY_W-1:0];
      bit_sel_s1_d  = ~pixel_x[CX_W-1:0];
      in_area_s1_d  = in_area;
      rd_ok_s1_d    = in_area && (state_q == RUN);
      match_s1_d    = cur_match;
      video_on_s1_d = video_on;
      rom_addr_d    = {code, glyph_row_q};
      bit_sel_d     = bit_sel_s1_q;
      cursor_hit_d  = match_s1_q && in_area_s1_q && blink_phase_q;
      pix_valid_d   = video_on_s1_q;
    end
  end

  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_start) begin
      if (32'(blink_cnt_q) == BLINK_FRAMES - 1) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      glyph_row_q   <= '0;
      bit_sel_s1_q  <= '0;
      in_area_s1_q  <= 1'b0;
      rd_ok_s1_q    <= 1'b0;
      match_s1_q    <= 1'b0;
      video_on_s1_q <= 1'b0;
      rom_addr_q    <= {BLANK, {CY_W{1'b0}}};
      bit_sel_q     <= '0;
      cursor_hit_q  <= 1'b0;
      pix_valid_q   <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else begin
      glyph_row_q   <= glyph_row_d;
      bit_sel_s1_q  <= bit_sel_s1_d;
      in_area_s1_q  <= in_area_s1_d;
      rd_ok_s1_q    <= rd_ok_s1_d;
      match_s1_q    <= match_s1_d;
      video_on_s1_q <= video_on_s1_d;
      rom_addr_q    <= rom_addr_d;
      bit_sel_q     <= bit_sel_d;
      cursor_hit_q  <= cursor_hit_d;
      pix_valid_q   <= pix_valid_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign bit_sel    = bit_sel_q;
  assign cursor_hit = cursor_hit_q;
  assign pix_valid  = pix_valid_q;

endmodule

// File: tb/tb_text_tile_addr_gen.sv
// Directed bench for text_tile_addr_gen with default parameters.
module tb_text_tile_addr_gen;

  logic        clk;
  logic        reset;
  logic        pixel_tick;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        video_on;
  logic        frame_start;
  logic        wr_en;
  logic [6:0]  wr_col;
  logic [4:0]  wr_row;
  logic [6:0]  wr_code;
  logic        wr_ready;
  logic        cursor_en;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [10:0] rom_addr;
  logic [2:0]  bit_sel;
  logic        cursor_hit;
  logic        pix_valid;

  int checks;
  int failures;

  text_tile_addr_gen dut (
    .clk         (clk),
    .reset       (reset),
    .pixel_tick  (pixel_tick),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .video_on    (video_on),
    .frame_start (frame_start),
    .wr_en       (wr_en),
    .wr_col      (wr_col),
    .wr_row      (wr_row),
    .wr_code     (wr_code),
    .wr_ready    (wr_ready),
    .cursor_en   (cursor_en),
    .cursor_col  (cursor_col),
    .cursor_row  (cursor_row),
    .rom_addr    (rom_addr),
    .bit_sel     (bit_sel),
    .cursor_hit  (cursor_hit),
    .pix_valid   (pix_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ticks(input int n);
    pixel_tick = 1'b1;
    step(n);
    pixel_tick = 1'b0;
  endtask

  task automatic set_pix(input int x, input int y, input logic von);
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = von;
  endtask

  task automatic write_cell(input int col, input int row, input int code);
    wr_en   = 1'b1;
    wr_col  = 7'(col);
    wr_row  = 5'(row);
    wr_code = 7'(code);
    step(1);
    wr_en   = 1'b0;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame_start = 1'b1;
      pixel_tick  = 1'b1;
      step(1);
      frame_start = 1'b0;
      pixel_tick  = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step(2);
    checks++;
    if (rom_addr !== 11'h000) begin
      failures++; $display("FAIL reset_rom_addr: got %h expected %h", rom_addr, 11'h000);
    end
    checks++;
    if (bit_sel !== 3'd0) begin
      failures++; $display("FAIL reset_bit_sel: got %0d expected 0", bit_sel);
    end
    checks++;
    if ({cursor_hit, pix_valid, wr_ready} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags: got hit=%b valid=%b ready=%b expected 0 0 0",
               cursor_hit, pix_valid, wr_ready);
    end
  endtask

  // Writes offered during clear must be dropped; clear takes one clk per cell.
  task automatic test_clear_count;
    int cnt;
    cnt = 0;
    reset = 1'b0;
    while (!wr_ready && cnt < 3000) begin
      wr_en   = (cnt < 5);
      wr_col  = 7'd0;
      wr_row  = 5'd0;
      wr_code = 7'h7F;
      step(1);
      cnt++;
    end
    wr_en = 1'b0;
    checks++;
    if (cnt != 2400 && cnt != 2401) begin
      failures++; $display("FAIL clear_count: got %0d clks expected 2400", cnt);
    end
  endtask

  task automatic test_blank_scan;
    for (int unsigned r = 0; r < 30; r++) begin
      for (int unsigned c = 0; c < 80; c++) begin
        set_pix(int'(c * 8), int'(r * 16), 1'b1);
        ticks(2);
        checks++;
        if (rom_addr !== 11'h000 || bit_sel !== 3'd7 || pix_valid !== 1'b1) begin
          failures++;
          $display("FAIL blank_scan c=%0d r=%0d: got addr=%h sel=%0d valid=%b expected 000 7 1",
                   c, r, rom_addr, bit_sel, pix_valid);
        end
      end
    end
  endtask

  task automatic test_write_read;
    write_cell(2, 0, 'h41);
    write_cell(79, 29, 'h23);
    write_cell(0, 1, 'h5A);
    set_pix(17, 5, 1'b1);
    ticks(2);
    checks++;
    if (rom_addr !== 11'h415 || bit_sel !== 3'd6 || pix_valid !== 1'b1) begin
      failures++;
      $display("FAIL read_c2r0: got addr=%h sel=%0d valid=%b expected 415 6 1",
               rom_addr, bit_sel, pix_valid);
    end
    set_pix(639, 479, 1'b1);
    ticks(2);
    checks++;
    if (rom_addr !== 11'h23F || bit_sel !== 3'd0) begin
      failures++;
      $display("FAIL read_last_cell: got addr=%h sel=%0d expected 23f 0", rom_addr, bit_sel);
    end
    set_pix(0, 16, 1'b1);
    ticks(2);
    checks++;
    if (rom_addr !== 11'h5A0 || bit_sel !== 3'd7) begin
      failures++;
      $display("FAIL read_c0r1: got addr=%h sel=%0d expected 5a0 7", rom_addr, bit_sel);
    end
  endtask

  task automatic test_out_of_area;
    set_pix(640, 100, 1'b1);
    ticks(2);
    checks++;
    if (rom_addr !== 11'h004 || pix_valid !== 1'b1) begin
      failures++;
      $display("FAIL oob_col: got addr=%h valid=%b expected 004 1", rom_addr, pix_valid);
    end
    set_pix(640, 100, 1'b0);
    ticks(2);
    checks++;
    if (rom_addr !== 11'h004 || pix_valid !== 1'b0) begin
      failures++;
      $display("FAIL video_off: got addr=%h valid=%b expected 004 0", rom_addr, pix_valid);
    end
    set_pix(17, 480, 1'b1);
    ticks(2);
    checks++;
    if (rom_addr !== 11'h000) begin
      failures++; $display("FAIL oob_row: got addr=%h expected 000", rom_addr);
    end
    set_pix(17, 5, 1'b0);
    ticks(2);
    checks++;
    if (rom_addr !== 11'h005 || pix_valid !== 1'b0) begin
      failures++;
      $display("FAIL blank_video_off: got addr=%h valid=%b expected 005 0", rom_addr, pix_valid);
    end
  endtask

  // col 85 on row 0 would alias onto cell (5,1) if not dropped.
  task automatic test_bad_write;
    write_cell(85, 0, 'h66);
    write_cell(3, 30, 'h66);
    set_pix(40, 16, 1'b1);
    ticks(2);
    checks++;
    if (rom_addr !== 11'h000) begin
      failures++; $display("FAIL bad_col_alias: got addr=%h expected 000", rom_addr);
    end
    set_pix(16, 0, 1'b1);
    ticks(2);
    checks++;
    if (rom_addr !== 11'h410) begin
      failures++; $display("FAIL bad_write_neighbour: got addr=%h expected 410", rom_addr);
    end
  endtask

  task automatic test_collision;
    set_pix(32, 0, 1'b1);
    wr_en      = 1'b1;
    wr_col     = 7'd4;
    wr_row     = 5'd0;
    wr_code    = 7'h11;
    pixel_tick = 1'b1;
    step(1);
    wr_en = 1'b0;
    step(1);
    checks++;
    if (rom_addr !== 11'h000) begin
      failures++; $display("FAIL collision_old: got addr=%h expected 000", rom_addr);
    end
    step(1);
    pixel_tick = 1'b0;
    checks++;
    if (rom_addr !== 11'h110) begin
      failures++; $display("FAIL collision_new: got addr=%h expected 110", rom_addr);
    end
  endtask

  task automatic test_cursor;
    cursor_en  = 1'b1;
    cursor_col = 7'd3;
    cursor_row = 5'd1;
    set_pix(27, 18, 1'b1);
    ticks(2);
    checks++;
    if (cursor_hit !== 1'b1 || rom_addr !== 11'h002) begin
      failures++;
      $display("FAIL cursor_on: got hit=%b addr=%h expected 1 002", cursor_hit, rom_addr);
    end
    set_pix(32, 18, 1'b1);
    ticks(2);
    checks++;
    if (cursor_hit !== 1'b0) begin
      failures++; $display("FAIL cursor_other_cell: got %b expected 0", cursor_hit);
    end
    cursor_en = 1'b0;
    set_pix(27, 18, 1'b1);
    ticks(2);
    checks++;
    if (cursor_hit !== 1'b0) begin
      failures++; $display("FAIL cursor_disabled: got %b expected 0", cursor_hit);
    end
    cursor_en = 1'b1;
    frames(29);
    ticks(2);
    checks++;
    if (cursor_hit !== 1'b1) begin
      failures++; $display("FAIL blink_29: got %b expected 1", cursor_hit);
    end
    frames(1);
    ticks(2);
    checks++;
    if (cursor_hit !== 1'b0) begin
      failures++; $display("FAIL blink_30: got %b expected 0", cursor_hit);
    end
    frames(29);
    ticks(2);
    checks++;
    if (cursor_hit !== 1'b0) begin
      failures++; $display("FAIL blink_59: got %b expected 0", cursor_hit);
    end
    frames(1);
    ticks(2);
    checks++;
    if (cursor_hit !== 1'b1) begin
      failures++; $display("FAIL blink_60: got %b expected 1", cursor_hit);
    end
    cursor_en = 1'b0;
  endtask

  task automatic test_hold;
    set_pix(17, 5, 1'b1);
    ticks(2);
    set_pix(640, 100, 1'b0);
    step(10);
    checks++;
    if (rom_addr !== 11'h415 || bit_sel !== 3'd6 || pix_valid !== 1'b1) begin
      failures++;
      $display("FAIL hold: got addr=%h sel=%0d valid=%b expected 415 6 1",
               rom_addr, bit_sel, pix_valid);
    end
    ticks(1);
    checks++;
    if (rom_addr !== 11'h415 || pix_valid !== 1'b1) begin
      failures++;
      $display("FAIL latency_1tick: got addr=%h valid=%b expected 415 1", rom_addr, pix_valid);
    end
    ticks(1);
    checks++;
    if (rom_addr !== 11'h004 || bit_sel !== 3'd7 || pix_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_2tick: got addr=%h sel=%0d valid=%b expected 004 7 0",
               rom_addr, bit_sel, pix_valid);
    end
  endtask

  task automatic test_reset_mid_clear;
    int cnt;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(990);
    set_pix(639, 479, 1'b1);
    ticks(2);
    checks++;
    if (rom_addr !== 11'h00F) begin
      failures++; $display("FAIL clear_forces_blank: got addr=%h expected 00f", rom_addr);
    end
    checks++;
    if (wr_ready !== 1'b0) begin
      failures++; $display("FAIL ready_mid_clear: got %b expected 0", wr_ready);
    end
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    checks++;
    if (wr_ready !== 1'b0) begin
      failures++; $display("FAIL ready_after_rereset: got %b expected 0", wr_ready);
    end
    cnt = 0;
    while (!wr_ready && cnt < 3000) begin
      step(1);
      cnt++;
    end
    checks++;
    if (cnt != 2400 && cnt != 2401) begin
      failures++; $display("FAIL reclear_count: got %0d clks expected 2400", cnt);
    end
    set_pix(639, 479, 1'b1);
    ticks(2);
    checks++;
    if (rom_addr !== 11'h00F) begin
      failures++; $display("FAIL reclear_last_cell: got addr=%h expected 00f", rom_addr);
    end
    set_pix(17, 5, 1'b1);
    ticks(2);
    checks++;
    if (rom_addr !== 11'h005) begin
      failures++; $display("FAIL reclear_c2r0: got addr=%h expected 005", rom_addr);
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    pixel_tick  = 1'b0;
    pixel_x     = '0;
    pixel_y     = '0;
    video_on    = 1'b0;
    frame_start = 1'b0;
    wr_en       = 1'b0;
    wr_col      = '0;
    wr_row      = '0;
    wr_code     = '0;
    cursor_en   = 1'b0;
    cursor_col  = '0;
    cursor_row  = '0;
    test_reset();
    test_clear_count();
    test_blank_scan();
    test_write_read();
    test_out_of_area();
    test_bad_write();
    test_collision();
    test_cursor();
    test_hold();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/text_tile_addr_gen.md
Name: text_tile_addr_gen

Overview:
- Parametrised text-mode tile address generator for the VGA controller, placed between the sync generator (pixel_x/pixel_y) and the font ROM.
- Holds a writable COLS x ROWS character buffer.
- Converts each pixel position into a font ROM address and a bit select, through a 2-stage pipeline that advances on pixel_tick.
- Adds automatic buffer clear after reset, out-of-area blanking and a blinking cursor overlay.

Parameters:
- X_W, 10, width of pixel_x
- Y_W, 10, width of pixel_y
- CHAR_W, 8, glyph width in pixels; power of 2
- CHAR_H, 16, glyph height in pixels; power of 2
- COLS, 80, text columns
- ROWS, 30, text rows
- CODE_W, 7, character code width
- BLANK_CODE, 0, code shown outside the text area and written by clear
- BLINK_FRAMES, 30, frames per cursor blink half-period

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pixel_tick  in  1  pixel enable; pipeline advances only when 1
- pixel_x  in  X_W  current pixel column
- pixel_y  in  Y_W  current pixel row
- video_on  in  1  visible-area flag from the sync generator
- frame_start  in  1  one-clk pulse per frame
- wr_en  in  1  buffer write request
- wr_col  in  clog2(COLS)  write column
- wr_row  in  clog2(ROWS)  write row
- wr_code  in  CODE_W  character code to write
- wr_ready  out  1  writes accepted (0 while clearing)
- cursor_en  in  1  cursor enable
- cursor_col  in  clog2(COLS)  cursor column
- cursor_row  in  clog2(ROWS)  cursor row
- rom_addr  out  CODE_W+clog2(CHAR_H)  {code, glyph_row} to the font ROM
- bit_sel  out  clog2(CHAR_W)  font-word bit to display
- cursor_hit  out  1  pixel lies in the visible cursor cell
- pix_valid  out  1  outputs correspond to a video_on pixel

Behaviour:
- Reset values:
  - rom_addr = {BLANK_CODE, 0}, bit_sel = 0, cursor_hit = 0, pix_valid = 0, wr_ready = 0.
  - Blink counter = 0, blink_phase = 1 (cursor visible).
  - FSM goes to CLEAR with clr_addr = 0.
- FSM CLEAR:
  - Each clk, write BLANK_CODE at clr_addr and increment it.
  - After address COLS*ROWS-1, go to RUN and set wr_ready = 1 on the next clk.
  - wr_en is ignored (dropped, not queued) while in CLEAR.
  - Reset asserted mid-clear restarts the clear from address 0.
- FSM RUN:
  - wr_en = 1 writes wr_code to address wr_row*COLS + wr_col in the same clk.
  - A write with wr_col >= COLS or wr_row >= ROWS is dropped.
  - RUN never returns to CLEAR except through reset.
- Address math, stage 1 (on pixel_tick):
  - col = pixel_x >> log2(CHAR_W); row = pixel_y >> log2(CHAR_H).
  - Register glyph_row = pixel_y mod CHAR_H and bit_sel_d = CHAR_W-1 - (pixel_x mod CHAR_W). The MSB of the font word is the leftmost pixel.
  - in_area = video_on & (col < COLS) & (row < ROWS).
  - Issue a synchronous buffer read at row*COLS + col.
  - Register cursor match = cursor_en & (col == cursor_col) & (row == cursor_row).
- Stage 2 (on pixel_tick):
  - code = in_area ? buffer data : BLANK_CODE.
  - rom_addr = {code, glyph_row}; bit_sel = bit_sel_d; pix_valid = video_on_d.
  - cursor_hit = match_d & in_area_d & blink_phase.
- Latency: exactly 2 pixel_tick events from pixel inputs to outputs. When pixel_tick = 0, all pipeline registers hold their values.
- Read/write collision on the same address in the same clk: the read returns the old data (read-before-write).
- While in CLEAR, the pipeline still runs, but code is forced to BLANK_CODE.
- Blink:
  - Each frame_start increments the counter.
  - When the counter reaches BLINK_FRAMES-1 and frame_start occurs, the counter resets to 0 and blink_phase toggles.
  - frame_start and pixel_tick in the same clk are both honoured independently.
- Widths: internal buffer address is clog2(COLS*ROWS) bits. The products row*COLS use that width; no truncation for the default parameters.

Decomposition:
- Shared package vga_text_pkg:
  - glyph and text-grid defaults (CHAR_W, CHAR_H, COLS, ROWS, CODE_W, BLANK_CODE);
  - FSM state encoding {CLEAR, RUN};
  - clog2-derived width constants.
- One sub-module: text_char_buffer, a single-port-write / single-port-read synchronous RAM of COLS*ROWS x CODE_W with read-before-write behaviour.
- FSM, pipeline and blink logic stay in the top module.

Test Plan:
- Reset, then count clks until wr_ready = 1 -> exactly COLS*ROWS = 2400 clks (+1). A full-screen scan then gives every rom_addr[10:4] = 0.
- Write code 0x41 at col 2, row 0; drive pixel_x = 17, pixel_y = 5, video_on = 1 -> after 2 ticks rom_addr = {0x41, 5} = 0x415, bit_sel = 6, pix_valid = 1.
- pixel_x = 640, pixel_y = 100 with video_on = 1 (col 80, out of area) -> rom_addr[10:4] = BLANK_CODE. Same coordinates with video_on = 0 -> pix_valid = 0.
- wr_en in CLEAR at col 0, row 0 with code 0x7F -> dropped, and the cell reads BLANK_CODE after clear. Write to wr_col = 85 in RUN -> ignored, and no cell changes.
- Cursor at (3,1), cursor_en = 1, pixel in that cell -> cursor_hit = 1. After 30 frame_start pulses -> cursor_hit = 0. After 60 pulses -> cursor_hit = 1 again.
- Assert reset midway through a 1000-clk clear -> wr_ready = 0, and the clear restarts, taking a full 2400 clks. Hold pixel_tick = 0 for 10 clks -> outputs stay unchanged.
